axil_h2c_vip: RTL and testbench



---
 rtl/axil_h2c_vip_pkg.sv | 22 ++
 rtl/axil_h2c_vip_h2c_pkt_gen.sv | 74 +++++++
 rtl/axil_h2c_vip.sv | 190 +++++++++++++++++++
 tb/tb_axil_h2c_vip.sv | 395 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_h2c_vip_pkg.sv
// Shared types for the host-side AXI-Lite / H2C stream stimulus master.
// Holds the register FSM encoding and the packed H2C sideband layout.
package axil_h2c_vip_pkg;

    localparam int TUSER_W    = 49;
    localparam int H2C_DATA_W = 512;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_WAIT_B,
        S_RD_A,
        S_WAIT_R
    } axil_state_e;

    typedef struct packed {
        logic [31:0] mdata;
        logic [5:0]  mty;
        logic [10:0] qid;
    } h2c_user_t;

endpackage

// File: rtl/axil_h2c_vip_h2c_pkt_gen.sv
// Packet generator: splits a byte length into 64-byte beats that carry
// their own beat index as fill data, with mty on the final beat.
module h2c_pkt_gen
    import axil_h2c_vip_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [15:0]           len,
    input  logic [10:0]           qid,
    input  logic                  slot,
    output logic                  busy,
    output logic                  beat_valid,
    output logic [H2C_DATA_W-1:0] beat_data,
    output h2c_user_t             beat_user,
    output logic                  beat_last
);

    logic [15:0] len_q;
    logic [10:0] qid_q;
    logic [10:0] nb_q;
    logic [10:0] idx_q;
    logic [10:0] nb_in;
    logic        accept;
    logic        fire;
    logic [15:0] cur_len;
    logic [10:0] cur_qid;
    logic [10:0] cur_nb;
    logic [10:0] cur_idx;

    assign accept     = start && !busy && (len != 16'd0);
    assign beat_valid = busy || accept;
    assign fire       = beat_valid && slot;
    assign nb_in      = {1'b0, len[15:6]} + {10'd0, |len[5:0]};

    // Beat 0 comes straight from the request so it can load on accept.
    always_comb begin
        cur_len   = busy ? len_q : len;
        cur_qid   = busy ? qid_q : qid;
        cur_nb    = busy ? nb_q : nb_in;
        cur_idx   = busy ? idx_q : 11'd0;
        beat_last = (cur_idx == cur_nb - 11'd1);
        beat_data = {64{cur_idx[7:0]}};
        beat_user = '{
            mdata: {16'd0, cur_len},
            mty:   beat_last ? 6'd0 - cur_len[5:0] : 6'd0,
            qid:   cur_qid
        };
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy  <= 1'b0;
            len_q <= '0;
            qid_q <= '0;
            nb_q  <= '0;
            idx_q <= '0;
        end else begin
            if (accept) begin
                len_q <= len;
                qid_q <= qid;
                nb_q  <= nb_in;
            end
            if (fire) begin
                idx_q <= beat_last ? 11'd0 : cur_idx + 11'd1;
                busy  <= !beat_last;
            end else if (accept) begin
                idx_q <= 11'd0;
                busy  <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/axil_h2c_vip.sv
// Host-side stimulus master: single-outstanding AXI4-Lite register
// commands plus a one-deep 512-bit H2C stream slice with a generator.
module axil_h2c_vip
    import axil_h2c_vip_pkg::*;
(
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [31:0]           cmd_addr,
    input  logic [31:0]           cmd_wdata,
    output logic                  rsp_valid,
    output logic                  rsp_write,
    output logic [31:0]           rsp_rdata,
    output logic [1:0]            rsp_resp,
    output logic [31:0]           m_axi_awaddr,
    output logic [2:0]            m_axi_awprot,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,
    output logic [31:0]           m_axi_wdata,
    output logic [3:0]            m_axi_wstrb,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,
    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,
    output logic [31:0]           m_axi_araddr,
    output logic [2:0]            m_axi_arprot,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [31:0]           m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready,
    input  logic                  h2c_in_valid,
    output logic                  h2c_in_ready,
    input  logic [H2C_DATA_W-1:0] h2c_in_data,
    input  logic [31:0]           h2c_in_mdata,
    input  logic [5:0]            h2c_in_mty,
    input  logic [10:0]           h2c_in_qid,
    input  logic                  h2c_in_last,
    input  logic                  gen_start,
    input  logic [15:0]           gen_len,
    input  logic [10:0]           gen_qid,
    output logic                  gen_busy,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [H2C_DATA_W-1:0] m_axis_tdata,
    output logic                  m_axis_tlast,
    output logic [TUSER_W-1:0]    m_axis_tuser
);

    axil_state_e state;

    assign m_axi_awprot = 3'b000;
    assign m_axi_arprot = 3'b000;
    assign m_axi_wstrb  = 4'hF;

    always_ff @(posedge aclk) begin
        if (areset) begin
            state         <= S_IDLE;
            cmd_ready     <= 1'b1;
            rsp_valid     <= 1'b0;
            rsp_write     <= 1'b0;
            rsp_rdata     <= '0;
            rsp_resp      <= '0;
            m_axi_awaddr  <= '0;
            m_axi_awvalid <= 1'b0;
            m_axi_wdata   <= '0;
            m_axi_wvalid  <= 1'b0;
            m_axi_bready  <= 1'b0;
            m_axi_araddr  <= '0;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    // cmd_ready re-arms one cycle after the response pulse.
                    if (cmd_ready && cmd_valid) begin
                        cmd_ready <= 1'b0;
                        if (cmd_write) begin
                            m_axi_awaddr  <= cmd_addr;
                            m_axi_wdata   <= cmd_wdata;
                            m_axi_awvalid <= 1'b1;
                            m_axi_wvalid  <= 1'b1;
                            state         <= S_WR;
                        end else begin
                            m_axi_araddr  <= cmd_addr;
                            m_axi_arvalid <= 1'b1;
                            state         <= S_RD_A;
                        end
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end
                S_WR: begin
                    if (m_axi_awready) m_axi_awvalid <= 1'b0;
                    if (m_axi_wready)  m_axi_wvalid  <= 1'b0;
                    if ((!m_axi_awvalid || m_axi_awready) &&
                        (!m_axi_wvalid || m_axi_wready)) begin
                        m_axi_bready <= 1'b1;
                        state        <= S_WAIT_B;
                    end
                end
                S_WAIT_B: begin
                    if (m_axi_bvalid) begin
                        m_axi_bready <= 1'b0;
                        rsp_valid    <= 1'b1;
                        rsp_write    <= 1'b1;
                        rsp_rdata    <= '0;
                        rsp_resp     <= m_axi_bresp;
                        state        <= S_IDLE;
                    end
                end
                S_RD_A: begin
                    if (m_axi_arready) begin
                        m_axi_arvalid <= 1'b0;
                        m_axi_rready  <= 1'b1;
                        state         <= S_WAIT_R;
                    end
                end
                S_WAIT_R: begin
                    if (m_axi_rvalid) begin
                        m_axi_rready <= 1'b0;
                        rsp_valid    <= 1'b1;
                        rsp_write    <= 1'b0;
                        rsp_rdata    <= m_axi_rdata;
                        rsp_resp     <= m_axi_rresp;
                        state        <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    logic                  slot;
    logic                  in_fire;
    logic                  gen_valid;
    logic [H2C_DATA_W-1:0] gen_data;
    h2c_user_t             gen_user;
    logic                  gen_last;
    h2c_user_t             tuser_q;

    assign slot         = !m_axis_tvalid || m_axis_tready;
    assign h2c_in_ready = slot && !gen_busy && !gen_start;
    assign in_fire      = h2c_in_valid && h2c_in_ready;
    assign m_axis_tuser = tuser_q;

    h2c_pkt_gen u_gen (
        .clk        (aclk),
        .rst        (areset),
        .start      (gen_start),
        .len        (gen_len),
        .qid        (gen_qid),
        .slot       (slot),
        .busy       (gen_busy),
        .beat_valid (gen_valid),
        .beat_data  (gen_data),
        .beat_user  (gen_user),
        .beat_last  (gen_last)
    );

    always_ff @(posedge aclk) begin
        if (areset) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
            tuser_q       <= '0;
        end else if (slot) begin
            m_axis_tvalid <= gen_valid || in_fire;
            if (gen_valid) begin
                m_axis_tdata <= gen_data;
                m_axis_tlast <= gen_last;
                tuser_q      <= gen_user;
            end else if (in_fire) begin
                m_axis_tdata <= h2c_in_data;
                m_axis_tlast <= h2c_in_last;
                tuser_q      <= '{
                    mdata: h2c_in_mdata,
                    mty:   h2c_in_mty,
                    qid:   h2c_in_qid
                };
            end
        end
    end

endmodule

// File: tb/tb_axil_h2c_vip.sv
// Directed + randomized bench for axil_h2c_vip with a queue-based
// stream reference model and a procedural AXI-Lite slave.
`timescale 1ns/1ps
module tb_axil_h2c_vip;

    logic         aclk = 1'b0;
    logic         areset = 1'b1;
    logic         cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [31:0]  cmd_addr = '0, cmd_wdata = '0;
    logic         rsp_valid, rsp_write;
    logic [31:0]  rsp_rdata;
    logic [1:0]   rsp_resp;
    logic [31:0]  m_axi_awaddr, m_axi_wdata, m_axi_araddr;
    logic [2:0]   m_axi_awprot, m_axi_arprot;
    logic [3:0]   m_axi_wstrb;
    logic         m_axi_awvalid, m_axi_wvalid, m_axi_arvalid;
    logic         m_axi_bready, m_axi_rready;
    logic         m_axi_awready = 1'b0, m_axi_wready = 1'b0;
    logic         m_axi_arready = 1'b0;
    logic [1:0]   m_axi_bresp = '0, m_axi_rresp = '0;
    logic         m_axi_bvalid = 1'b0, m_axi_rvalid = 1'b0;
    logic [31:0]  m_axi_rdata = '0;
    logic         h2c_in_valid = 1'b0, h2c_in_ready, h2c_in_last = 1'b0;
    logic [511:0] h2c_in_data = '0;
    logic [31:0]  h2c_in_mdata = '0;
    logic [5:0]   h2c_in_mty = '0;
    logic [10:0]  h2c_in_qid = '0;
    logic         gen_start = 1'b0, gen_busy;
    logic [15:0]  gen_len = '0;
    logic [10:0]  gen_qid = '0;
    logic         m_axis_tvalid, m_axis_tready = 1'b1, m_axis_tlast;
    logic [511:0] m_axis_tdata;
    logic [48:0]  m_axis_tuser;

    always #2 aclk = ~aclk;

    axil_h2c_vip dut (
        .aclk(aclk), .areset(areset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
        .m_axi_bready(m_axi_bready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
        .h2c_in_valid(h2c_in_valid), .h2c_in_ready(h2c_in_ready),
        .h2c_in_data(h2c_in_data), .h2c_in_mdata(h2c_in_mdata),
        .h2c_in_mty(h2c_in_mty), .h2c_in_qid(h2c_in_qid),
        .h2c_in_last(h2c_in_last),
        .gen_start(gen_start), .gen_len(gen_len), .gen_qid(gen_qid),
        .gen_busy(gen_busy),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
        .m_axis_tuser(m_axis_tuser)
    );

    typedef struct {
        logic [511:0] data;
        logic [48:0]  user;
        logic         last;
    } beat_t;

    beat_t exp_q[$];
    beat_t got_q[$];
    beat_t prev_b;
    int    checks = 0;
    int    errors = 0;
    bit    mon_on = 0;
    bit    rand_ready = 0;
    bit    prev_stall = 0;

    task automatic check(string tag, logic [511:0] obs, logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Stream monitor: samples 1 ns before the rising edge.
    always @(negedge aclk) begin
        #1;
        if (mon_on) begin
            if (prev_stall) begin
                check("stall_valid", m_axis_tvalid, 1);
                check("stall_data", m_axis_tdata, prev_b.data);
                check("stall_user", m_axis_tuser, prev_b.user);
                check("stall_last", m_axis_tlast, prev_b.last);
            end
            prev_b = '{m_axis_tdata, m_axis_tuser, m_axis_tlast};
            if (m_axis_tvalid && m_axis_tready) got_q.push_back(prev_b);
            prev_stall = m_axis_tvalid && !m_axis_tready;
        end else begin
            prev_stall = 0;
        end
    end

    always @(posedge aclk) begin
        if (rand_ready) begin
            #1;
            m_axis_tready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    // Reference: a len-byte packet is ceil(len/64) beats of index fill.
    task automatic model_pkt(int len, int qid);
        int nb;
        nb = (len + 63) / 64;
        for (int i = 0; i < nb; i++) begin
            beat_t b;
            logic [7:0] byt;
            int mty;
            byt = i[7:0];
            for (int j = 0; j < 64; j++) b.data[j*8 +: 8] = byt;
            b.last = (i == nb - 1);
            mty = b.last ? nb * 64 - len : 0;
            b.user = {16'd0, 16'(len), 6'(mty), 11'(qid)};
            exp_q.push_back(b);
        end
    endtask

    task automatic start_gen(int len, int qid);
        @(negedge aclk);
        gen_start = 1'b1;
        gen_len = 16'(len);
        gen_qid = 11'(qid);
        @(negedge aclk);
        gen_start = 1'b0;
        if (len != 0) model_pkt(len, qid);
    endtask

    task automatic drain(string tag);
        int n;
        n = 0;
        while ((got_q.size() < exp_q.size() || gen_busy) && n < 3000) begin
            @(negedge aclk);
            n++;
        end
        repeat (3) @(negedge aclk);
        check({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check({tag, "_data"}, got_q[i].data, exp_q[i].data);
            check({tag, "_user"}, got_q[i].user, exp_q[i].user);
            check({tag, "_last"}, got_q[i].last, exp_q[i].last);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic send_beats(int n, bit use_pat);
        beat_t b;
        int k, sent;
        bit need;
        k = 0;
        sent = 0;
        need = 1;
        while (sent < n && k < 500) begin
            @(negedge aclk);
            if (use_pat) m_axis_tready = (k == 1 || k == 2) ? 1'b0 : 1'b1;
            if (need) begin
                for (int j = 0; j < 16; j++) b.data[j*32 +: 32] = $urandom;
                h2c_in_data  = b.data;
                h2c_in_mdata = $urandom;
                h2c_in_mty   = 6'($urandom);
                h2c_in_qid   = 11'($urandom);
                h2c_in_last  = 1'($urandom_range(0, 1));
                b.user = {h2c_in_mdata, h2c_in_mty, h2c_in_qid};
                b.last = h2c_in_last;
                h2c_in_valid = 1'b1;
                need = 0;
            end
            #1;
            if (h2c_in_ready) begin
                exp_q.push_back(b);
                sent++;
                need = 1;
            end
            k++;
        end
        check("send_done", sent, n);
        @(negedge aclk);
        h2c_in_valid = 1'b0;
    endtask

    task automatic send_cmd(bit wr, logic [31:0] a, logic [31:0] d);
        int n;
        n = 0;
        @(negedge aclk);
        while (!cmd_ready && n < 50) begin
            @(negedge aclk);
            n++;
        end
        check("cmd_ready_wait", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_wdata = d;
        @(negedge aclk);
        cmd_valid = 1'b0;
    endtask

    task automatic finish_rsp(bit wr, logic [31:0] rd, logic [1:0] rs);
        check("rsp_valid", rsp_valid, 1);
        check("rsp_write", rsp_write, wr);
        check("rsp_rdata", rsp_rdata, rd);
        check("rsp_resp", rsp_resp, rs);
        @(negedge aclk);
        check("rsp_pulse", rsp_valid, 0);
        check("cmd_ready_back", cmd_ready, 1);
    endtask

    task automatic do_write(logic [31:0] a, logic [31:0] d,
                            int awd, int wd, int bd, logic [1:0] br);
        bit aw_done, w_done, aw_hs, w_hs;
        int k;
        aw_done = 0;
        w_done = 0;
        k = 0;
        send_cmd(1'b1, a, d);
        while (!(aw_done && w_done) && k < 40) begin
            aw_hs = 0;
            w_hs = 0;
            if (aw_done) check("awvalid_drop", m_axi_awvalid, 0);
            else begin
                check("awvalid", m_axi_awvalid, 1);
                check("awaddr", m_axi_awaddr, a);
                check("awprot", m_axi_awprot, 0);
                aw_hs = (k >= awd);
            end
            if (w_done) check("wvalid_drop", m_axi_wvalid, 0);
            else begin
                check("wvalid", m_axi_wvalid, 1);
                check("wdata", m_axi_wdata, d);
                check("wstrb", m_axi_wstrb, 4'hF);
                w_hs = (k >= wd);
            end
            m_axi_awready = aw_hs;
            m_axi_wready = w_hs;
            @(negedge aclk);
            aw_done |= aw_hs;
            w_done |= w_hs;
            k++;
        end
        m_axi_awready = 1'b0;
        m_axi_wready = 1'b0;
        check("aw_w_idle", {m_axi_awvalid, m_axi_wvalid}, 0);
        check("bready", m_axi_bready, 1);
        repeat (bd) @(negedge aclk);
        m_axi_bvalid = 1'b1;
        m_axi_bresp = br;
        @(negedge aclk);
        m_axi_bvalid = 1'b0;
        finish_rsp(1'b1, 32'd0, br);
    endtask

    task automatic do_read(logic [31:0] a, int ard, int rdl,
                           logic [31:0] rd, logic [1:0] rr);
        bit done, hs;
        int k;
        done = 0;
        k = 0;
        send_cmd(1'b0, a, 32'd0);
        while (!done && k < 40) begin
            check("arvalid", m_axi_arvalid, 1);
            check("araddr", m_axi_araddr, a);
            check("arprot", m_axi_arprot, 0);
            hs = (k >= ard);
            m_axi_arready = hs;
            @(negedge aclk);
            done = hs;
            k++;
        end
        m_axi_arready = 1'b0;
        check("arvalid_drop", m_axi_arvalid, 0);
        check("rready", m_axi_rready, 1);
        repeat (rdl) @(negedge aclk);
        m_axi_rvalid = 1'b1;
        m_axi_rdata = rd;
        m_axi_rresp = rr;
        @(negedge aclk);
        m_axi_rvalid = 1'b0;
        m_axi_rdata = $urandom;
        finish_rsp(1'b0, rd, rr);
    endtask

    task automatic do_reset();
        @(negedge aclk);
        areset = 1'b1;
        repeat (3) @(negedge aclk);
        areset = 1'b0;
        @(negedge aclk);
    endtask

    initial begin
        do_reset();
        check("rst_tvalid", m_axis_tvalid, 0);
        check("rst_tuser", m_axis_tuser, 0);
        check("rst_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid}, 0);
        check("rst_readies", {m_axi_bready, m_axi_rready}, 0);
        check("rst_rsp", rsp_valid, 0);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_gen_busy", gen_busy, 0);

        do_write(32'h0000_1000, 32'hDEAD_BEEF, 3, 0, 1, 2'd0);
        do_read(32'h0000_0004, 0, 1, 32'h1234_5678, 2'd2);
        for (int i = 0; i < 8; i++) begin
            if ($urandom_range(0, 1) == 1)
                do_write($urandom, $urandom, $urandom_range(0, 4),
                         $urandom_range(0, 4), $urandom_range(0, 3),
                         2'($urandom));
            else
                do_read($urandom, $urandom_range(0, 4),
                        $urandom_range(0, 3), $urandom, 2'($urandom));
        end

        mon_on = 1;
        m_axis_tready = 1'b1;
        // Generator request and a pass-through beat in the same cycle.
        @(negedge aclk);
        gen_start = 1'b1;
        gen_len = 16'd100;
        gen_qid = 11'd5;
        h2c_in_valid = 1'b1;
        h2c_in_data = {16{32'hA5A5_5A5A}};
        #1;
        check("start_wins", h2c_in_ready, 0);
        @(negedge aclk);
        gen_start = 1'b0;
        h2c_in_valid = 1'b0;
        check("gen100_busy", gen_busy, 1);
        #1;
        check("busy_blocks_in", h2c_in_ready, 0);
        @(negedge aclk);
        check("gen100_done", gen_busy, 0);
        model_pkt(100, 5);
        drain("gen100");

        start_gen(64, 17);
        drain("gen64");
        start_gen(65, 2047);
        drain("gen65");
        start_gen(0, 3);
        check("len0_busy", gen_busy, 0);
        check("len0_tvalid", m_axis_tvalid, 0);
        drain("gen0");

        send_beats(3, 1'b1);
        drain("bp");

        rand_ready = 1;
        for (int i = 0; i < 4; i++) begin
            start_gen($urandom_range(1, 400), $urandom_range(0, 2047));
            drain("gen_rand");
            send_beats($urandom_range(2, 8), 1'b0);
            drain("pass_rand");
        end
        @(negedge aclk);
        rand_ready = 0;
        m_axis_tready = 1'b0;

        start_gen(300, 9);
        repeat (2) @(negedge aclk);
        mon_on = 0;
        areset = 1'b1;
        @(negedge aclk);
        check("abort_tvalid", m_axis_tvalid, 0);
        check("abort_tlast", m_axis_tlast, 0);
        check("abort_busy", gen_busy, 0);
        check("abort_cmd_ready", cmd_ready, 1);
        areset = 1'b0;
        m_axis_tready = 1'b1;
        got_q.delete();
        exp_q.delete();
        repeat (2) @(negedge aclk);
        check("post_abort_tvalid", m_axis_tvalid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
